booth_mul_scheduler: RTL and testbench
======================================

// Module: booth_mul_scheduler
// PURPOSE
//  Shares one sequential 32x32 radix-4 Booth multiplier (ports CLK, RST, in_a, in_b, Product, Product_Valid)
//  among N_REQ requesters. Round-robin arbitration, operand capture, restart of the multiplier through its RST,
//  wait for Product_Valid, return of the 64-bit signed product to the granted requester. Sits between client
//  blocks and a single multiplier instance.
// PARAMETERS
//  N_REQ    4    number of requesters (2..8)
//  WIDTH    32   operand width; result is 2*WIDTH
//  TIMEOUT  48   max RUN cycles waiting for mul_valid before abort (> 34)
// PORTS
//  CLK          in   1              clock, rising edge
//  RST          in   1              asynchronous reset, active-high
//  req          in   N_REQ          level request per requester
//  req_a        in   N_REQ*WIDTH    multiplicand, requester i at [i*WIDTH +: WIDTH], signed
//  req_b        in   N_REQ*WIDTH    multiplier, same packing, signed
//  gnt          out  N_REQ          one-hot grant, high for the whole operation
//  done         out  N_REQ          one-cycle pulse to the served requester; result/err valid that cycle
//  result       out  2*WIDTH        signed product, held until next done
//  err          out  1              high with done when operation timed out (result = 0)
//  busy         out  1              high in RUN and DONE
//  mul_rst      out  1              drives multiplier RST; high = multiplier held idle
//  mul_a        out  WIDTH          drives multiplier in_a (registered)
//  mul_b        out  WIDTH          drives multiplier in_b (registered)
//  mul_product  in   2*WIDTH        multiplier Product
//  mul_valid    in   1              multiplier Product_Valid
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, gnt=0, done=0, result=0, err=0, busy=0, mul_rst=1, mul_a=mul_b=0, ptr=0,
//    wait_cnt=0. Operation in flight is dropped; no done is issued for it.
//  All outputs registered. FSM states IDLE, RUN, DONE.
//  IDLE: mul_rst=1. If req!=0: winner = first set bit scanning ptr, ptr+1, ... wrapping mod N_REQ.
//    Same edge: gnt<=onehot(winner), mul_a/mul_b<=winner's operands, mul_rst<=0, wait_cnt<=0, busy<=1, -> RUN.
//  RUN: mul_a/mul_b frozen; multiplier samples them on its first edge with RST low; wait_cnt increments each cycle.
//    mul_valid=1: result<=mul_product, err<=0, done<=gnt, gnt<=0, mul_rst<=1, ptr<=(winner+1) mod N_REQ, -> DONE.
//    else wait_cnt==TIMEOUT-1: result<=0, err<=1, done<=gnt, gnt<=0, mul_rst<=1, ptr advances as above, -> DONE.
//    mul_valid takes priority over timeout when both occur in the same cycle.
//  DONE: one cycle; done<=0, err<=0, busy<=0, -> IDLE. Next arbitration is in IDLE (min 1 idle cycle between ops).
//  Latency: req high in IDLE at edge t -> gnt at t+1 -> done = 1 cycle after the cycle mul_valid is seen
//    (nominally ~34 cycles after gnt with the 16-step multiplier).
//  Handshake: requester holds req until it sees done, drops it next cycle; req still high in IDLE re-arbitrates
//    at ptr's new (rotated) priority. Operand/req changes after grant are ignored; req dropping in RUN does not
//    abort the operation; done still pulses.
//  mul_valid outside RUN ignored. req bits for index >= N_REQ do not exist. Product is sign-correct for all
//    WIDTH-bit signed operands, including -2^31 * -2^31 = 2^62.
// TESTING
//  1 req=0001, a=3, b=-5 -> gnt=0001 one cycle later, done=0001 single pulse, result=64'hFFFFFFFFFFFFFFF1, err=0.
//  2 req=1111 held, each drops after own done -> service order 0,1,2,3; re-raise 0 with 1..3 -> order 1,2,3,0.
//  3 Multiplier model never asserts mul_valid -> after 48 RUN cycles done pulses, err=1, result=0, mul_rst=1.
//  4 RST pulse mid-RUN (cycle 10) -> gnt=0, done never pulses, mul_rst=1, next req=0100 served normally.
//  5 Change req_a of granted requester from 7 to 9 mid-RUN with b=6 -> result=42; mul_valid pulse in IDLE -> no done.
//  6 a=32'h80000000, b=32'h80000000 -> result=64'h4000000000000000; a=-1, b=1 -> all-ones.

Source files
------------

// File: rtl/booth_mul_scheduler.sv
// ---------------------------------------------------------------------------
// booth_mul_scheduler
//
// Shares one sequential WIDTHxWIDTH signed multiplier among N_REQ requesters.
// A round-robin arbiter picks one requester. Its operands are captured into
// mul_a/mul_b and the multiplier is released from reset. The scheduler then
// waits for mul_valid, or gives up after TIMEOUT cycles. The signed product,
// or zero with err set on timeout, is returned with a one-cycle done pulse
// to the requester that was served.
//
// Ports
//   CLK          clock, rising edge
//   RST          asynchronous reset, active-high
//   req          level request per requester
//   req_a/req_b  packed signed operands, requester i at [i*WIDTH +: WIDTH]
//   gnt          one-hot grant, held for the whole operation
//   done         one-cycle pulse to the served requester
//   result       signed product, held until the next done
//   err          high with done when the operation timed out (result = 0)
//   busy         high while an operation is running or completing
//   mul_rst      multiplier reset; high keeps the multiplier idle
//   mul_a/mul_b  registered multiplier operands
//   mul_product  multiplier product
//   mul_valid    multiplier product-valid
// ---------------------------------------------------------------------------
module booth_mul_scheduler #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 48
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*WIDTH-1:0]   req_a,
    input  logic [N_REQ*WIDTH-1:0]   req_b,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_REQ-1:0]         done,
    output logic [2*WIDTH-1:0]       result,
    output logic                     err,
    output logic                     busy,
    output logic                     mul_rst,
    output logic [WIDTH-1:0]         mul_a,
    output logic [WIDTH-1:0]         mul_b,
    input  logic [2*WIDTH-1:0]       mul_product,
    input  logic                     mul_valid
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [PTR_W-1:0]     owner_q, owner_d;
    logic [CNT_W-1:0]     wait_cnt_q, wait_cnt_d;

    logic [N_REQ-1:0]     gnt_d, done_d;
    logic [2*WIDTH-1:0]   result_d;
    logic                 err_d, busy_d, mul_rst_d;
    logic [WIDTH-1:0]     mul_a_d, mul_b_d;

    // Unpacked operand views so the winner can be selected by index.
    logic [WIDTH-1:0]     a_arr [N_REQ];
    logic [WIDTH-1:0]     b_arr [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign a_arr[i] = req_a[i*WIDTH +: WIDTH];
        assign b_arr[i] = req_b[i*WIDTH +: WIDTH];
    end

    // Round-robin pick: first set request scanning ptr, ptr+1, ... with
    // wrap-around modulo N_REQ (which need not be a power of two).
    logic             found;
    logic [PTR_W-1:0] winner;

    always_comb begin
        int idx;
        // NOTE: every variable assigned in always_comb gets a default first,
        // so no path leaves it unassigned and no latch is inferred.
        found  = 1'b0;
        winner = ptr_q;
        idx    = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!found && req[PTR_W'(idx)]) begin
                found  = 1'b1;
                winner = PTR_W'(idx);
            end
        end
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        wait_cnt_d = wait_cnt_q;
        gnt_d      = gnt;
        done_d     = '0;
        result_d   = result;
        err_d      = err;
        busy_d     = busy;
        mul_rst_d  = mul_rst;
        mul_a_d    = mul_a;
        mul_b_d    = mul_b;

        case (state_q)
            S_IDLE: begin
                mul_rst_d = 1'b1;
                if (found) begin
                    state_d        = S_RUN;
                    owner_d        = winner;
                    gnt_d          = '0;
                    gnt_d[winner]  = 1'b1;
                    mul_a_d        = a_arr[winner];
                    mul_b_d        = b_arr[winner];
                    mul_rst_d      = 1'b0;
                    wait_cnt_d     = '0;
                    busy_d         = 1'b1;
                end
            end

            S_RUN: begin
                wait_cnt_d = wait_cnt_q + 1'b1;
                // A valid product wins over a timeout in the same cycle.
                if (mul_valid || (wait_cnt_q == CNT_LAST)) begin
                    result_d  = mul_valid ? mul_product : '0;
                    err_d     = !mul_valid;
                    done_d    = gnt;
                    gnt_d     = '0;
                    mul_rst_d = 1'b1;
                    ptr_d     = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
                    state_d   = S_DONE;
                end
            end

            S_DONE: begin
                err_d   = 1'b0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            owner_q    <= '0;
            wait_cnt_q <= '0;
            gnt        <= '0;
            done       <= '0;
            result     <= '0;
            err        <= 1'b0;
            busy       <= 1'b0;
            mul_rst    <= 1'b1;
            mul_a      <= '0;
            mul_b      <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            wait_cnt_q <= wait_cnt_d;
            gnt        <= gnt_d;
            done       <= done_d;
            result     <= result_d;
            err        <= err_d;
            busy       <= busy_d;
            mul_rst    <= mul_rst_d;
            mul_a      <= mul_a_d;
            mul_b      <= mul_b_d;
        end
    end

endmodule

// File: tb/tb_booth_mul_scheduler.sv
// ---------------------------------------------------------------------------
// tb_booth_mul_scheduler
//
// Self-checking bench for booth_mul_scheduler. A behavioural multiplier model
// answers the scheduler with a programmable latency. Expected responses are
// pushed into a scoreboard queue when a request is issued. A monitor process
// tracks the round-robin order at transaction level. It also pops and
// compares a scoreboard entry on every done pulse.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_booth_mul_scheduler;

    localparam int N_REQ   = 4;
    localparam int WIDTH   = 32;
    localparam int TIMEOUT = 48;
    localparam int RW      = 2 * WIDTH;

    logic                   CLK = 1'b0;
    logic                   RST;
    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] req_a, req_b;
    logic [N_REQ-1:0]       gnt, done;
    logic [RW-1:0]          result;
    logic                   err, busy, mul_rst;
    logic [WIDTH-1:0]       mul_a, mul_b;
    logic [RW-1:0]          mul_product;
    logic                   mul_valid;

    booth_mul_scheduler #(
        .N_REQ   (N_REQ),
        .WIDTH   (WIDTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .req         (req),
        .req_a       (req_a),
        .req_b       (req_b),
        .gnt         (gnt),
        .done        (done),
        .result      (result),
        .err         (err),
        .busy        (busy),
        .mul_rst     (mul_rst),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_product (mul_product),
        .mul_valid   (mul_valid)
    );

    always #5 CLK = ~CLK;

    // ---------------- reference arithmetic ----------------
    function automatic logic [RW-1:0] smul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic signed [RW-1:0] sa, sb, p;
        sa = {{WIDTH{a[WIDTH-1]}}, a};
        sb = {{WIDTH{b[WIDTH-1]}}, b};
        p  = sa * sb;
        return p;
    endfunction

    function automatic int rr_pick(input int p, input logic [N_REQ-1:0] r);
        for (int k = 0; k < N_REQ; k++) begin
            if (r[(p + k) % N_REQ]) return (p + k) % N_REQ;
        end
        return -1;
    endfunction

    function automatic logic [N_REQ-1:0] onehot(input int i);
        logic [N_REQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // ---------------- multiplier model ----------------
    // Captures operands on its first edge out of reset, raises valid after
    // m_lat edges and holds it until put back into reset.
    logic          m_valid;
    logic          m_spur;
    logic          m_never;
    int            m_lat;
    int            m_cnt;
    logic [RW-1:0] m_prod;

    assign mul_valid   = m_valid | m_spur;
    assign mul_product = m_prod;

    always @(posedge CLK) begin
        if (mul_rst) begin
            m_cnt   <= 0;
            m_valid <= 1'b0;
            m_prod  <= '0;
        end else if (!m_never) begin
            if (m_cnt == 0) m_prod <= smul(mul_a, mul_b);
            m_cnt <= m_cnt + 1;
            if (m_cnt + 1 >= m_lat) m_valid <= 1'b1;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        int            idx;
        logic [RW-1:0] res;
        logic          e;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   last_run_len = 0;
    int   done_count = 0;

    task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: actual=%h expected=%h", name, act, expv);
        end
    endtask

    task automatic issue(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit to);
        exp_t e;
        req_a[i*WIDTH +: WIDTH] = a;
        req_b[i*WIDTH +: WIDTH] = b;
        req[i] = 1'b1;
        e.idx = i;
        e.res = to ? '0 : smul(a, b);
        e.e   = to;
        exp_q.push_back(e);
    endtask

    // Waits (bounded) for a done pulse, then the requester drops its req.
    task automatic wait_done(output int idx);
        idx = -1;
        for (int c = 0; c < 200; c++) begin
            @(negedge CLK);
            if (done != '0) begin
                for (int i = 0; i < N_REQ; i++) if (done[i]) idx = i;
                req[idx] = 1'b0;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL done_timeout: actual=no done within 200 cycles expected=done pulse");
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        req = '0;
        exp_q.delete();
        @(negedge CLK);
        RST = 1'b0;
    endtask

    // ---------------- monitor ----------------
    int               mstate = 0;
    int               cur = 0;
    int               model_ptr = 0;
    int               run_len = 0;
    int               pos;
    logic [N_REQ-1:0] last_req;

    initial begin
        forever begin
            @(posedge CLK);
            last_req = req;
            #1;
            if (RST) begin
                check("rst_gnt", gnt, '0);
                check("rst_done", done, '0);
                check("rst_busy", busy, '0);
                check("rst_mul_rst", mul_rst, 1);
                check("rst_result", result, '0);
                check("rst_err", err, '0);
                check("rst_mul_a", mul_a, '0);
                mstate    = 0;
                model_ptr = 0;
            end else begin
                case (mstate)
                    0: begin
                        check("idle_done", done, '0);
                        if (last_req != '0) begin
                            cur = rr_pick(model_ptr, last_req);
                            check("grant", gnt, onehot(cur));
                            check("busy_run", busy, 1);
                            run_len = 0;
                            mstate  = 1;
                        end else begin
                            check("idle_gnt", gnt, '0);
                        end
                    end
                    1: begin
                        run_len++;
                        if (done != '0) begin
                            check("done_onehot", done, onehot(cur));
                            check("done_gnt_clear", gnt, '0);
                            check("done_busy", busy, 1);
                            pos = -1;
                            foreach (exp_q[k]) if (pos < 0 && exp_q[k].idx == cur) pos = k;
                            if (pos >= 0) begin
                                check("result", result, exp_q[pos].res);
                                check("err", err, exp_q[pos].e);
                                exp_q.delete(pos);
                            end else begin
                                checks++;
                                errors++;
                                $display("FAIL unexpected_done: actual=done for %0d expected=no outstanding op", cur);
                            end
                            done_count++;
                            last_run_len = run_len;
                            model_ptr    = (cur + 1) % N_REQ;
                            mstate       = 2;
                        end else begin
                            check("gnt_hold", gnt, onehot(cur));
                            if (run_len > TIMEOUT + 2) begin
                                checks++;
                                errors++;
                                $display("FAIL run_overrun: actual=%0d cycles expected<=%0d", run_len, TIMEOUT);
                                mstate = 0;
                            end
                        end
                    end
                    default: begin
                        check("done_pulse", done, '0);
                        check("busy_idle", busy, 0);
                        mstate = 0;
                    end
                endcase
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=simulation still running expected=finished");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    function automatic logic [WIDTH-1:0] rand_op();
        case ($urandom_range(0, 5))
            0:       return 32'h8000_0000;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h0;
            default: return $urandom;
        endcase
    endfunction

    int idx;
    int dc0;
    int exp_order[5] = '{0, 1, 2, 3, 0};

    initial begin
        RST     = 1'b1;
        req     = '0;
        req_a   = '0;
        req_b   = '0;
        m_spur  = 1'b0;
        m_never = 1'b0;
        m_lat   = 34;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);

        // 1: single request, 3 * -5
        issue(0, 32'd3, 32'hFFFF_FFFB, 1'b0);
        @(posedge CLK);
        #1;
        check("t1_gnt", gnt, 4'b0001);
        check("t1_mul_a", mul_a, 32'd3);
        check("t1_mul_b", mul_b, 32'hFFFF_FFFB);
        check("t1_mul_rst", mul_rst, 0);
        wait_done(idx);
        check("t1_idx", idx, 0);
        check("t1_result", result, 64'hFFFF_FFFF_FFFF_FFF1);
        check("t1_err", err, 0);

        // 2: all four held from ptr=0; requester 0 re-raises after its done
        do_reset();
        @(negedge CLK);
        for (int i = 0; i < N_REQ; i++) issue(i, 32'(i + 10), 32'hFFFF_FF00 + 32'(i), 1'b0);
        wait_done(idx);
        check("t2_order0", idx, exp_order[0]);
        @(negedge CLK);
        issue(0, 32'd77, 32'd5, 1'b0);
        for (int n = 1; n < 5; n++) begin
            wait_done(idx);
            check("t2_order", idx, exp_order[n]);
        end

        // 3: multiplier never answers -> timeout
        @(negedge CLK);
        m_never = 1'b1;
        issue(2, 32'd5, 32'd7, 1'b1);
        wait_done(idx);
        check("t3_idx", idx, 2);
        check("t3_run_len", last_run_len, TIMEOUT);
        check("t3_err", err, 1);
        check("t3_result", result, '0);
        check("t3_mul_rst", mul_rst, 1);
        m_never = 1'b0;

        // 4: reset pulse mid-operation drops it
        @(negedge CLK);
        issue(1, 32'd11, 32'd13, 1'b0);
        repeat (10) @(negedge CLK);
        check("t4_gnt_before", gnt, 4'b0010);
        dc0 = done_count;
        RST = 1'b1;
        req = '0;
        exp_q.delete();
        #1;
        check("t4_async_gnt", gnt, '0);
        check("t4_async_mul_rst", mul_rst, 1);
        @(negedge CLK);
        RST = 1'b0;
        repeat (40) @(negedge CLK);
        check("t4_no_done", done_count, dc0);
        issue(2, 32'd20, 32'hFFFF_FFFD, 1'b0);
        wait_done(idx);
        check("t4_idx", idx, 2);
        check("t4_result", result, 64'hFFFF_FFFF_FFFF_FFC4);

        // 5: operand and req changes after grant are ignored; stray valid in IDLE
        @(negedge CLK);
        issue(3, 32'd7, 32'd6, 1'b0);
        @(posedge CLK);
        #1;
        check("t5_gnt", gnt, 4'b1000);
        repeat (3) @(negedge CLK);
        req_a[3*WIDTH +: WIDTH] = 32'd9;
        req[3] = 1'b0;
        wait_done(idx);
        check("t5_idx", idx, 3);
        check("t5_result", result, 64'd42);
        repeat (3) @(negedge CLK);
        dc0 = done_count;
        m_spur = 1'b1;
        @(negedge CLK);
        m_spur = 1'b0;
        repeat (5) @(negedge CLK);
        check("t5_spur_no_done", done_count, dc0);
        check("t5_spur_gnt", gnt, '0);

        // 6: sign corner cases
        issue(0, 32'h8000_0000, 32'h8000_0000, 1'b0);
        wait_done(idx);
        check("t6_min_min", result, 64'h4000_0000_0000_0000);
        @(negedge CLK);
        issue(1, 32'hFFFF_FFFF, 32'd1, 1'b0);
        wait_done(idx);
        check("t6_neg1", result, 64'hFFFF_FFFF_FFFF_FFFF);

        // Random traffic with random multiplier latency
        for (int it = 0; it < 400; it++) begin
            logic [N_REQ-1:0] dropped;
            @(negedge CLK);
            dropped = done;
            req     = req & ~done;
            m_lat   = int'($urandom_range(1, 40));
            for (int i = 0; i < N_REQ; i++) begin
                if (!req[i] && !dropped[i] && $urandom_range(0, 3) == 0) begin
                    issue(i, rand_op(), rand_op(), 1'b0);
                end
            end
        end
        for (int c = 0; c < 2000 && exp_q.size() != 0; c++) begin
            @(negedge CLK);
            req = req & ~done;
        end
        check("drain_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
